// File: rtl/mem_wrapper.sv
// mem_wrapper
//   One 128x64 gain-cell DRAM bank in a chain of banks. Serves user reads and
//   writes, accepts refresh data streamed from the previous ("old") bank, and on
//   request sweeps its own contents out on o_rd so the next bank can copy them.
//
// Build option
//   REF_INDICATOR_QUAL_EN  when defined, a refresh write from the old bank also
//                          requires i_sr_indicator_old=1. Default: ignored.
//
// Ports
//   i_clk, i_rst                    clock (rising edge), async active-high reset
//   i_u_data_in/i_u_write_addr      user write data/address
//   i_u_we_current                  user write enable, this bank
//   i_u_read_addr/i_u_re_current    user read address/enable, this bank
//   i_u_we_old/i_u_re_old           user access targets the previous bank
//   i_ref_en_old                    previous bank streams refresh data in
//   i_ref_data_in/i_sr_addr_old     refresh data and its address
//   i_sr_indicator_old              previous bank's valid flag for refresh data
//   i_ref_en_current                own sweep allowed (level)
//   i_start_sr                      1-cycle pulse, start own sweep
//   o_rd                            read data (user read or sweep word)
//   o_sr_addr_current_out           address of sweep word on o_rd
//   o_sr_ref_indicator_current_out  o_rd carries a valid sweep word
//   o_ref_done                      pulses with the last sweep word
//
// Sweep FSM
//   state   | meaning
//   S_IDLE  | no sweep; o_rd only changes on user reads
//   S_SWEEP | emitting mem[r_cnt] on every cycle without user access
module mem_wrapper #(
  parameter int DW    = 64,
  parameter int AW    = 7,
  parameter int DEPTH = 2**AW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_u_data_in,
  input  logic [AW-1:0] i_u_write_addr,
  input  logic          i_u_we_current,
  input  logic [AW-1:0] i_u_read_addr,
  input  logic          i_u_re_current,
  input  logic          i_u_we_old,
  input  logic          i_u_re_old,
  input  logic          i_ref_en_old,
  input  logic [DW-1:0] i_ref_data_in,
  input  logic [AW-1:0] i_sr_addr_old,
  input  logic          i_sr_indicator_old,
  input  logic          i_ref_en_current,
  input  logic          i_start_sr,
  output logic [DW-1:0] o_rd,
  output logic [AW-1:0] o_sr_addr_current_out,
  output logic          o_sr_ref_indicator_current_out,
  output logic          o_ref_done
);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [DW-1:0] r_mem [DEPTH];
  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_rd;
  logic [AW-1:0] r_sr_addr;
  logic          r_ind;
  logic          r_done;

  logic w_ref_we;
  logic w_user_busy;

  // The old bank's output is shared with its user port, so any user access
  // there means the streamed refresh word is not valid this cycle.
`ifdef REF_INDICATOR_QUAL_EN
  assign w_ref_we = i_ref_en_old & ~i_u_we_old & ~i_u_re_old & i_sr_indicator_old;
`else
  assign w_ref_we = i_ref_en_old & ~i_u_we_old & ~i_u_re_old;
  logic w_unused_sr_indicator;
  assign w_unused_sr_indicator = i_sr_indicator_old;
`endif

  assign w_user_busy = i_u_re_current | i_u_we_current;

  // Array is never reset. User write is issued last so it wins a same-address
  // collision with the refresh write.
  always_ff @(posedge i_clk) begin
    if (w_ref_we)
      r_mem[i_sr_addr_old] <= i_ref_data_in;
    if (i_u_we_current)
      r_mem[i_u_write_addr] <= i_u_data_in;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_sr_addr <= '0;
      r_ind     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_ind  <= 1'b0;
      r_done <= 1'b0;
      // Read-before-write: r_mem still holds the pre-edge value here.
      if (i_u_re_current)
        r_rd <= r_mem[i_u_read_addr];
      case (r_state)
        S_IDLE: begin
          if (i_start_sr && i_ref_en_current) begin
            r_state <= S_SWEEP;
            r_cnt   <= '0;
          end
        end
        S_SWEEP: begin
          if (!i_ref_en_current) begin
            r_state <= S_IDLE;
          end else if (!w_user_busy) begin
            r_rd      <= r_mem[r_cnt];
            r_sr_addr <= r_cnt;
            r_ind     <= 1'b1;
            r_cnt     <= r_cnt + 1'b1;
            if (r_cnt == LAST_ADDR) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign o_rd                           = r_rd;
  assign o_sr_addr_current_out          = r_sr_addr;
  assign o_sr_ref_indicator_current_out = r_ind;
  assign o_ref_done                     = r_done;

endmodule

// File: tb/tb_mem_wrapper.sv
module tb_mem_wrapper;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] u_data_in, ref_data_in;
  logic [6:0]  u_write_addr, u_read_addr, sr_addr_old;
  logic        u_we_current, u_re_current, u_we_old, u_re_old;
  logic        ref_en_old, sr_indicator_old, ref_en_current, start_sr;
  wire  [63:0] rd;
  wire  [6:0]  sr_addr_out;
  wire         sr_ind_out, ref_done;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: word array plus a sweep pointer
  logic [63:0] m_mem [128];
  bit          m_sweeping;
  int          m_idx;
  logic [63:0] exp_rd;
  logic [6:0]  exp_addr;
  logic        exp_ind, exp_done;

  always #5 clk = ~clk;

  mem_wrapper dut (
    .i_clk                          (clk),
    .i_rst                          (rst),
    .i_u_data_in                    (u_data_in),
    .i_u_write_addr                 (u_write_addr),
    .i_u_we_current                 (u_we_current),
    .i_u_read_addr                  (u_read_addr),
    .i_u_re_current                 (u_re_current),
    .i_u_we_old                     (u_we_old),
    .i_u_re_old                     (u_re_old),
    .i_ref_en_old                   (ref_en_old),
    .i_ref_data_in                  (ref_data_in),
    .i_sr_addr_old                  (sr_addr_old),
    .i_sr_indicator_old             (sr_indicator_old),
    .i_ref_en_current               (ref_en_current),
    .i_start_sr                     (start_sr),
    .o_rd                           (rd),
    .o_sr_addr_current_out          (sr_addr_out),
    .o_sr_ref_indicator_current_out (sr_ind_out),
    .o_ref_done                     (ref_done)
  );

  task automatic idle_inputs();
    u_data_in = '0; ref_data_in = '0; u_write_addr = '0; u_read_addr = '0;
    sr_addr_old = '0; u_we_current = 0; u_re_current = 0; u_we_old = 0;
    u_re_old = 0; ref_en_old = 0; sr_indicator_old = 0; ref_en_current = 0;
    start_sr = 0;
  endtask

  task automatic model_reset();
    m_sweeping = 0; m_idx = 0;
    exp_rd = '0; exp_addr = '0; exp_ind = 0; exp_done = 0;
  endtask

  // Expected outputs after the coming edge, from the current inputs.
  task automatic model_step();
    bit ref_ok;
    exp_ind  = 0;
    exp_done = 0;
    if (u_re_current) exp_rd = m_mem[u_read_addr];
    if (m_sweeping) begin
      if (!ref_en_current) m_sweeping = 0;
      else if (!u_re_current && !u_we_current) begin
        exp_rd   = m_mem[m_idx];
        exp_addr = 7'(m_idx);
        exp_ind  = 1;
        if (m_idx == 127) begin
          exp_done   = 1;
          m_sweeping = 0;
        end
        m_idx = m_idx + 1;
      end
    end else if (start_sr && ref_en_current) begin
      m_sweeping = 1;
      m_idx      = 0;
    end
    ref_ok = ref_en_old && !u_we_old && !u_re_old;
`ifdef REF_INDICATOR_QUAL_EN
    ref_ok = ref_ok && sr_indicator_old;
`endif
    if (ref_ok) m_mem[sr_addr_old] = ref_data_in;
    if (u_we_current) m_mem[u_write_addr] = u_data_in;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (rd !== 64'd0) $display("FAIL reset_rd: got %0h want 0", rd); else n_pass++;
    n_checks++; if (sr_ind_out !== 1'b0) $display("FAIL reset_ind: got %b want 0", sr_ind_out); else n_pass++;
    n_checks++; if (ref_done !== 1'b0) $display("FAIL reset_done: got %b want 0", ref_done); else n_pass++;
    n_checks++; if (sr_addr_out !== 7'd0) $display("FAIL reset_addr: got %0d want 0", sr_addr_out); else n_pass++;
    rst = 0;
  endtask

  task automatic test_user_rw();
    idle_inputs();
    u_we_current = 1; u_write_addr = 10; u_data_in = 9;
    cycle();
    idle_inputs();
    u_re_current = 1; u_read_addr = 10;
    cycle();
    n_checks++; if (rd !== 64'd9) $display("FAIL user_read: got %0d want 9", rd); else n_pass++;
    idle_inputs();
    cycle();
    n_checks++; if (rd !== 64'd9) $display("FAIL rd_hold: got %0d want 9", rd); else n_pass++;
    // same-address read and write: old data first, new data next
    u_re_current = 1; u_read_addr = 10; u_we_current = 1; u_write_addr = 10; u_data_in = 77;
    cycle();
    n_checks++; if (rd !== 64'd9) $display("FAIL rbw_old: got %0d want 9", rd); else n_pass++;
    idle_inputs();
    u_re_current = 1; u_read_addr = 10;
    cycle();
    n_checks++; if (rd !== 64'd77) $display("FAIL rbw_new: got %0d want 77", rd); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_refresh_fill();
    idle_inputs();
    for (int i = 0; i < 128; i++) begin
      ref_en_old = 1; sr_indicator_old = 1; sr_addr_old = 7'(i); ref_data_in = 64'(i + 1);
      cycle();
    end
    idle_inputs();
    for (int i = 0; i < 128; i++) begin
      u_re_current = 1; u_read_addr = 7'(i);
      cycle();
      n_checks++;
      if (rd !== 64'(i + 1)) $display("FAIL refresh_fill[%0d]: got %0d want %0d", i, rd, i + 1);
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_refresh_blocked();
    idle_inputs();
    ref_en_old = 1; sr_indicator_old = 1; sr_addr_old = 3; ref_data_in = 555; u_we_old = 1;
    cycle();
    ref_en_old = 1; sr_indicator_old = 1; sr_addr_old = 4; ref_data_in = 666; u_we_old = 0; u_re_old = 1;
    cycle();
    idle_inputs();
    u_re_current = 1; u_read_addr = 3;
    cycle();
    n_checks++; if (rd !== 64'd4) $display("FAIL blocked_we_old: got %0d want 4", rd); else n_pass++;
    u_read_addr = 4;
    cycle();
    n_checks++; if (rd !== 64'd5) $display("FAIL blocked_re_old: got %0d want 5", rd); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_collision();
    idle_inputs();
    for (int i = 0; i < 128; i++) begin
      ref_en_old = 1; sr_indicator_old = 1; sr_addr_old = 7'(i); ref_data_in = 64'(i + 1);
      u_we_current = 1; u_write_addr = 7'(i); u_data_in = 64'(900 + i);
      cycle();
    end
    // different addresses on the same edge: both land
    ref_en_old = 1; sr_addr_old = 20; ref_data_in = 111;
    u_we_current = 1; u_write_addr = 21; u_data_in = 222;
    cycle();
    idle_inputs();
    for (int i = 0; i < 128; i++) begin
      u_re_current = 1; u_read_addr = 7'(i);
      cycle();
      if (i != 20 && i != 21) begin
        n_checks++;
        if (rd !== 64'(900 + i)) $display("FAIL user_wins[%0d]: got %0d want %0d", i, rd, 900 + i);
        else n_pass++;
      end else begin
        n_checks++;
        if (rd !== (i == 20 ? 64'd111 : 64'd222))
          $display("FAIL dual_write[%0d]: got %0d want %0d", i, rd, (i == 20 ? 111 : 222));
        else n_pass++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_random_traffic();
    idle_inputs();
    for (int c = 0; c < 1500; c++) begin
      u_we_current     = ($urandom_range(99) < 30);
      u_re_current     = ($urandom_range(99) < 40);
      u_write_addr     = 7'($urandom);
      u_read_addr      = 7'($urandom);
      u_data_in        = {$urandom, $urandom};
      ref_en_old       = ($urandom_range(99) < 60);
      u_we_old         = ($urandom_range(99) < 20);
      u_re_old         = ($urandom_range(99) < 20);
      sr_indicator_old = ($urandom_range(99) < 70);
      sr_addr_old      = 7'($urandom);
      ref_data_in      = {$urandom, $urandom};
      cycle();
      n_checks++;
      if (rd !== exp_rd || sr_ind_out !== 1'b0)
        $display("FAIL rand_traffic[%0d]: got rd=%0h ind=%b want rd=%0h ind=0", c, rd, sr_ind_out, exp_rd);
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_sweep();
    int words = 0;
    idle_inputs();
    ref_en_current = 1; start_sr = 1;
    cycle();
    start_sr = 0;
    for (int c = 0; c < 140; c++) begin
      cycle();
      if (sr_ind_out === 1'b1) begin
        n_checks++;
        if (sr_addr_out !== 7'(words) || rd !== exp_rd || ref_done !== (words == 127))
          $display("FAIL sweep_word[%0d]: got addr=%0d rd=%0h done=%b want addr=%0d rd=%0h done=%b",
                   words, sr_addr_out, rd, ref_done, words, exp_rd, words == 127);
        else n_pass++;
        words++;
      end else begin
        n_checks++;
        if (ref_done !== 1'b0 || sr_ind_out !== exp_ind)
          $display("FAIL sweep_idle[%0d]: got ind=%b done=%b want ind=%b done=0", c, sr_ind_out, ref_done, exp_ind);
        else n_pass++;
      end
    end
    n_checks++; if (words != 128) $display("FAIL sweep_count: got %0d want 128", words); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_sweep_stall();
    int words = 0;
    idle_inputs();
    ref_en_current = 1; start_sr = 1;
    cycle();
    start_sr = 0;
    for (int c = 0; c < 140; c++) begin
      u_re_current = (c == 40); u_read_addr = 5;
      cycle();
      if (c == 40) begin
        n_checks++;
        if (sr_ind_out !== 1'b0 || rd !== exp_rd || rd !== 64'd905)
          $display("FAIL stall_user: got ind=%b rd=%0h want ind=0 rd=%0h", sr_ind_out, rd, exp_rd);
        else n_pass++;
      end else if (sr_ind_out === 1'b1) begin
        n_checks++;
        if (sr_addr_out !== 7'(words) || rd !== exp_rd)
          $display("FAIL stall_word[%0d]: got addr=%0d rd=%0h want addr=%0d rd=%0h",
                   words, sr_addr_out, rd, words, exp_rd);
        else n_pass++;
        words++;
      end
    end
    n_checks++; if (words != 128) $display("FAIL stall_count: got %0d want 128", words); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_abort();
    int words = 0;
    int dones = 0;
    idle_inputs();
    ref_en_current = 1; start_sr = 1;
    cycle();
    start_sr = 0;
    for (int c = 0; c < 20; c++) begin
      start_sr = (c == 10);   // ignored mid-sweep
      cycle();
      if (sr_ind_out === 1'b1) begin
        n_checks++;
        if (sr_addr_out !== 7'(words))
          $display("FAIL restart_ignored[%0d]: got addr=%0d want %0d", c, sr_addr_out, words);
        else n_pass++;
        words++;
      end
    end
    start_sr = 0; ref_en_current = 0;
    cycle();
    ref_en_current = 1;
    for (int c = 0; c < 140; c++) begin
      cycle();
      if (sr_ind_out !== 1'b0 || ref_done !== 1'b0) dones++;
    end
    n_checks++; if (dones != 0) $display("FAIL abort: got %0d active cycles want 0", dones); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_mid_sweep();
    int active = 0;
    idle_inputs();
    ref_en_current = 1; start_sr = 1;
    cycle();
    start_sr = 0;
    repeat (30) cycle();
    #2 rst = 1;
    #1;
    model_reset();
    n_checks++;
    if (rd !== 64'd0 || sr_ind_out !== 1'b0 || sr_addr_out !== 7'd0)
      $display("FAIL async_reset: got rd=%0h ind=%b addr=%0d want 0 0 0", rd, sr_ind_out, sr_addr_out);
    else n_pass++;
    @(posedge clk); #1;
    rst = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (sr_ind_out !== 1'b0) active++;
    end
    n_checks++; if (active != 0) $display("FAIL reset_idle: got %0d active want 0", active); else n_pass++;
    ref_en_current = 0; u_re_current = 1; u_read_addr = 77;
    cycle();
    n_checks++;
    if (rd !== exp_rd || rd !== 64'd977) $display("FAIL reset_keeps_mem: got %0h want %0h", rd, exp_rd);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_random_sweep();
    idle_inputs();
    for (int c = 0; c < 2500; c++) begin
      ref_en_current   = ($urandom_range(999) < 995);
      start_sr         = ($urandom_range(99) < 5);
      u_we_current     = ($urandom_range(99) < 12);
      u_re_current     = ($urandom_range(99) < 12);
      u_write_addr     = 7'($urandom);
      u_read_addr      = 7'($urandom);
      u_data_in        = {$urandom, $urandom};
      ref_en_old       = ($urandom_range(99) < 50);
      u_we_old         = ($urandom_range(99) < 15);
      u_re_old         = ($urandom_range(99) < 15);
      sr_indicator_old = ($urandom_range(99) < 70);
      sr_addr_old      = 7'($urandom);
      ref_data_in      = {$urandom, $urandom};
      cycle();
      n_checks++;
      if (rd !== exp_rd || sr_addr_out !== exp_addr || sr_ind_out !== exp_ind || ref_done !== exp_done)
        $display("FAIL rand_sweep[%0d]: got rd=%0h a=%0d i=%b d=%b want rd=%0h a=%0d i=%b d=%b",
                 c, rd, sr_addr_out, sr_ind_out, ref_done, exp_rd, exp_addr, exp_ind, exp_done);
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_user_rw();
    test_refresh_fill();
    test_refresh_blocked();
    test_collision();
    test_sweep();
    test_sweep_stall();
    test_abort();
    test_reset_mid_sweep();
    test_random_traffic();
    test_random_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
